// File: rtl/main_memory_sync.sv
// Clocked word-addressed main memory with programmable wait states and a RD/WR/ACK four-phase handshake.
// Optional feature macro: MAIN_MEMORY_WRITE_PROTECT_EN (read-only program region below PROTECT_LIMIT).
module main_memory_sync #(
    parameter int                       DATAWIDTH_BUS = 32,
    parameter int                       ADDRWIDTH     = 8,
    parameter int                       WAIT_STATES   = 2,
    parameter logic [DATAWIDTH_BUS-1:0] NOP_WORD      = DATAWIDTH_BUS'(32'h0100_0000),
    parameter string                    INIT_FILE     = "main_memory.hex",
    parameter int                       PROTECT_LIMIT = 14
) (
    input  logic                     MAIN_MEMORY_SYNC_CLOCK_50,
    input  logic                     MAIN_MEMORY_SYNC_ResetInLow_In,
    input  logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_SYNC_A_InBus,
    input  logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_SYNC_B_InBus,
    input  logic                     MAIN_MEMORY_SYNC_RD_In,
    input  logic                     MAIN_MEMORY_SYNC_WRMain_In,
    output logic                     MAIN_MEMORY_SYNC_ACK_Out,
    output logic                     MAIN_MEMORY_SYNC_ERR_Out,
    output logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_SYNC_Data_OutBus
);

    localparam int DEPTH    = 1 << ADDRWIDTH;
    localparam int MEM_BITS = DEPTH * DATAWIDTH_BUS;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Built-in boot program forming the power-up image of the program region.
    function automatic logic [DATAWIDTH_BUS-1:0] boot_word(input int i);
        boot_word = NOP_WORD;
        case (i)
            0: boot_word = DATAWIDTH_BUS'(32'h9080_200A);
            1: boot_word = DATAWIDTH_BUS'(32'h8280_2001);
            2: boot_word = DATAWIDTH_BUS'(32'h8480_6003);
            3: boot_word = DATAWIDTH_BUS'(32'h8E81_4006);
            4: boot_word = DATAWIDTH_BUS'(32'h8800_4002);
            5: boot_word = DATAWIDTH_BUS'(32'h0280_0004);
            6: boot_word = DATAWIDTH_BUS'(32'h8A81_2001);
            7: boot_word = DATAWIDTH_BUS'(32'h1080_0003);
            default: boot_word = NOP_WORD;
        endcase
    endfunction

    function automatic logic [MEM_BITS-1:0] load_image();
        logic [DATAWIDTH_BUS-1:0] words [DEPTH];
        logic [MEM_BITS-1:0]      img;
        for (int i = 0; i < DEPTH; i++) begin
            words[i] = (i < PROTECT_LIMIT) ? boot_word(i) : NOP_WORD;
        end
        img = '0;
        for (int i = 0; i < DEPTH; i++) begin
            img[i*DATAWIDTH_BUS +: DATAWIDTH_BUS] = words[i];
        end
        return img;
    endfunction

    // Array contents survive reset; only the power-up image initialises them.
    logic [MEM_BITS-1:0] mem = load_image();

    logic [1:0]               state;
    logic [3:0]               cnt;
    logic                     req_q;
    logic                     wr_q;
    logic [DATAWIDTH_BUS-1:0] a_q;
    logic [DATAWIDTH_BUS-1:0] b_q;
    logic                     op_wr;
    logic [DATAWIDTH_BUS-1:0] addr;
    logic [DATAWIDTH_BUS-1:0] wdata;
    logic                     ack;
    logic                     err;
    logic [DATAWIDTH_BUS-1:0] data;

    logic [ADDRWIDTH-1:0]     idx;
    logic                     in_range;
    logic                     protect_hit;
    logic                     finish;
    logic                     commit;
    logic                     req_now;
    logic [DATAWIDTH_BUS-1:0] rd_word;

    assign idx      = addr[ADDRWIDTH-1:0];
    assign in_range = ~|addr[DATAWIDTH_BUS-1:ADDRWIDTH];
    assign rd_word  = mem[int'(idx)*DATAWIDTH_BUS +: DATAWIDTH_BUS];
    assign req_now  = MAIN_MEMORY_SYNC_RD_In | MAIN_MEMORY_SYNC_WRMain_In;
    assign finish   = (state == S_WAIT) && (cnt == 4'd0);

`ifdef MAIN_MEMORY_WRITE_PROTECT_EN
    assign protect_hit = op_wr && in_range && (int'(idx) < PROTECT_LIMIT);
`else
    assign protect_hit = 1'b0;
`endif

    assign commit = finish && op_wr && in_range && !protect_hit;

    // Requests are registered first, so an access sampled at edge k is accepted at edge k+1.
    always_ff @(posedge MAIN_MEMORY_SYNC_CLOCK_50) begin
        if (!MAIN_MEMORY_SYNC_ResetInLow_In) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            req_q <= 1'b0;
            wr_q  <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            op_wr <= 1'b0;
            addr  <= '0;
            wdata <= '0;
            ack   <= 1'b0;
            err   <= 1'b0;
            data  <= NOP_WORD;
        end else begin
            req_q <= req_now;
            wr_q  <= MAIN_MEMORY_SYNC_WRMain_In;
            a_q   <= MAIN_MEMORY_SYNC_A_InBus;
            b_q   <= MAIN_MEMORY_SYNC_B_InBus;
            case (state)
                S_IDLE: begin
                    if (req_q) begin
                        op_wr <= wr_q;
                        addr  <= a_q;
                        wdata <= b_q;
                        cnt   <= 4'(WAIT_STATES);
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (finish) begin
                        state <= S_DONE;
                        ack   <= 1'b1;
                        err   <= protect_hit;
                        if (!op_wr) begin
                            data <= in_range ? rd_word : NOP_WORD;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    if (!req_now) begin
                        state <= S_IDLE;
                        ack   <= 1'b0;
                        err   <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge MAIN_MEMORY_SYNC_CLOCK_50) begin
        if (MAIN_MEMORY_SYNC_ResetInLow_In && commit) begin
            mem[int'(idx)*DATAWIDTH_BUS +: DATAWIDTH_BUS] <= wdata;
        end
    end

    assign MAIN_MEMORY_SYNC_ACK_Out     = ack;
    assign MAIN_MEMORY_SYNC_ERR_Out     = err;
    assign MAIN_MEMORY_SYNC_Data_OutBus = data;

endmodule

// File: tb/tb_main_memory_sync.sv
// Bench for main_memory_sync: reset, vector table, reset/early-drop sequences and random accesses
// checked against an array model of the memory.
module tb_main_memory_sync;

    localparam int          WS    = 2;
    localparam int          DEPTH = 256;
    localparam int          PLIM  = 14;
    localparam logic [31:0] NOP   = 32'h0100_0000;
`ifdef MAIN_MEMORY_WRITE_PROTECT_EN
    localparam bit PROT_ON = 1'b1;
`else
    localparam bit PROT_ON = 1'b0;
`endif
    localparam logic [31:0] W3_AFTER = PROT_ON ? 32'h8E81_4006 : 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] b;
    logic        ack;
    logic        err;
    logic [31:0] dout;

    always #5 clk = ~clk;

    main_memory_sync #(
        .WAIT_STATES(WS),
        .INIT_FILE  ("")
    ) dut (
        .MAIN_MEMORY_SYNC_CLOCK_50     (clk),
        .MAIN_MEMORY_SYNC_ResetInLow_In(rst_n),
        .MAIN_MEMORY_SYNC_A_InBus      (a),
        .MAIN_MEMORY_SYNC_B_InBus      (b),
        .MAIN_MEMORY_SYNC_RD_In        (rd),
        .MAIN_MEMORY_SYNC_WRMain_In    (wr),
        .MAIN_MEMORY_SYNC_ACK_Out      (ack),
        .MAIN_MEMORY_SYNC_ERR_Out      (err),
        .MAIN_MEMORY_SYNC_Data_OutBus  (dout)
    );

    typedef struct {
        bit          wr;
        bit          rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
        bit          exp_err;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_mem [DEPTH];
    bit          known     [DEPTH];
    int          known_q[$];
    logic [31:0] last_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] addr);
        return addr < DEPTH;
    endfunction

    function automatic bit is_prot(input logic [31:0] addr);
        return PROT_ON && (addr < PLIM);
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] wd);
        if (in_rng(addr) && !is_prot(addr)) begin
            model_mem[int'(addr)] = wd;
            if (!known[int'(addr)]) begin
                known[int'(addr)] = 1'b1;
                known_q.push_back(int'(addr));
            end
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        return in_rng(addr) ? model_mem[int'(addr)] : NOP;
    endfunction

    function automatic vec_t mk(input bit w, input bit r, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] ed, input bit ee);
        vec_t v;
        v.wr = w; v.rd = r; v.a = addr; v.b = wd; v.exp_data = ed; v.exp_err = ee;
        return v;
    endfunction

    // One full handshake; early=1 drops the request while the access is still waiting.
    task automatic do_access(input bit w, input bit r, input logic [31:0] addr, input logic [31:0] wd,
                             input bit early, input string tag,
                             output logic [31:0] dq, output logic eq);
        int lat;
        bit got;
        @(negedge clk);
        wr = w; rd = r; a = addr; b = wd;
        lat = 0;
        got = 1'b0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(posedge clk); #1;
            if (ack) begin
                got = 1'b1;
                lat = c;
            end else if (early && c == 2) begin
                wr = 1'b0; rd = 1'b0;
            end
        end
        check({tag, " ack_seen"}, 32'(got), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(WS + 3));
        dq = dout;
        eq = err;
        if (!early) begin
            @(posedge clk); #1;
            check({tag, " ack_hold"}, 32'(ack), 32'd1);
            wr = 1'b0; rd = 1'b0;
        end
        @(posedge clk); #1;
        check({tag, " ack_drop"}, 32'(ack), 32'd0);
        check({tag, " err_drop"}, 32'(err), 32'd0);
    endtask

    vec_t        vecs [16];
    logic [31:0] dq;
    logic        eq;

    initial begin
        rst_n = 1'b0; rd = 1'b1; wr = 1'b0; a = '0; b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = '0;
            known[i]     = 1'b0;
        end
        model_mem[0] = 32'h9080_200A; known[0] = 1'b1; known_q.push_back(0);
        model_mem[3] = 32'h8E81_4006; known[3] = 1'b1; known_q.push_back(3);

        vecs[0]  = mk(0, 1, 32'd0,         32'h0,         32'h9080_200A, 1'b0);
        vecs[1]  = mk(0, 1, 32'd3,         32'h0,         32'h8E81_4006, 1'b0);
        vecs[2]  = mk(1, 0, 32'd40,        32'hDEAD_BEEF, 32'h8E81_4006, 1'b0);
        vecs[3]  = mk(0, 1, 32'd40,        32'h0,         32'hDEAD_BEEF, 1'b0);
        vecs[4]  = mk(0, 1, 32'h0000_0100, 32'h0,         NOP,           1'b0);
        vecs[5]  = mk(1, 0, 32'h0000_0100, 32'h1234_5678, NOP,           1'b0);
        vecs[6]  = mk(1, 0, 32'h8000_0028, 32'hCAFE_F00D, NOP,           1'b0);
        vecs[7]  = mk(0, 1, 32'd0,         32'h0,         32'h9080_200A, 1'b0);
        vecs[8]  = mk(0, 1, 32'd40,        32'h0,         32'hDEAD_BEEF, 1'b0);
        vecs[9]  = mk(1, 0, 32'd3,         32'h0,         32'hDEAD_BEEF, PROT_ON);
        vecs[10] = mk(0, 1, 32'd3,         32'h0,         W3_AFTER,      1'b0);
        vecs[11] = mk(1, 1, 32'd50,        32'd5,         W3_AFTER,      1'b0);
        vecs[12] = mk(0, 1, 32'd50,        32'h0,         32'd5,         1'b0);
        vecs[13] = mk(1, 0, 32'd51,        32'h5151_5151, 32'd5,         1'b0);
        vecs[14] = mk(1, 0, 32'd255,       32'hFFFF_0001, 32'd5,         1'b0);
        vecs[15] = mk(0, 1, 32'd255,       32'h0,         32'hFFFF_0001, 1'b0);

        // Reset held for two edges with a read request pending.
        repeat (2) @(posedge clk);
        #1;
        check("reset ack",  32'(ack), 32'd0);
        check("reset err",  32'(err), 32'd0);
        check("reset data", dout, NOP);
        @(negedge clk);
        rst_n = 1'b1; rd = 1'b0;

        for (int i = 0; i < 16; i++) begin
            do_access(vecs[i].wr, vecs[i].rd, vecs[i].a, vecs[i].b, 1'b0, $sformatf("vec%0d", i), dq, eq);
            check($sformatf("vec%0d data", i), dq, vecs[i].exp_data);
            check($sformatf("vec%0d err", i), 32'(eq), 32'(vecs[i].exp_err));
            if (vecs[i].wr) model_write(vecs[i].a, vecs[i].b);
            last_data = vecs[i].exp_data;
        end

        // Request released while the access is still waiting.
        do_access(1'b0, 1'b1, 32'd40, 32'h0, 1'b1, "early", dq, eq);
        check("early data", dq, model_read(32'd40));
        last_data = model_read(32'd40);

        // Reset lands in the middle of a write: nothing committed, no ACK.
        begin
            bit ack_seen;
            @(negedge clk);
            wr = 1'b1; a = 32'd51; b = 32'hAAAA_5555;
            repeat (3) @(posedge clk);
            @(negedge clk);
            rst_n = 1'b0; wr = 1'b0;
            ack_seen = 1'b0;
            repeat (2) begin
                @(posedge clk); #1;
                if (ack) ack_seen = 1'b1;
            end
            @(negedge clk);
            rst_n = 1'b1;
            repeat (6) begin
                @(posedge clk); #1;
                if (ack) ack_seen = 1'b1;
            end
            check("midreset no_ack", 32'(ack_seen), 32'd0);
            check("midreset data", dout, NOP);
            do_access(1'b0, 1'b1, 32'd51, 32'h0, 1'b0, "midreset read", dq, eq);
            check("midreset word51", dq, model_read(32'd51));
            last_data = model_read(32'd51);
        end

        for (int n = 0; n < 80; n++) begin
            bit          w;
            bit          r;
            bit          early;
            logic [31:0] addr;
            logic [31:0] wd;
            logic [31:0] exp_d;
            bit          exp_e;
            early = ($urandom_range(0, 5) == 0);
            wd    = $urandom;
            if ($urandom_range(0, 7) < 3) begin
                w = 1'b1;
                r = ($urandom_range(0, 3) == 0);
                addr = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h0000_0100) : 32'($urandom_range(0, DEPTH - 1));
                exp_d = last_data;
                exp_e = in_rng(addr) && is_prot(addr);
            end else begin
                w = 1'b0;
                r = 1'b1;
                addr = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h0000_0100)
                                                   : 32'(known_q[$urandom_range(0, known_q.size() - 1)]);
                exp_d = model_read(addr);
                exp_e = 1'b0;
                last_data = exp_d;
            end
            do_access(w, r, addr, wd, early, $sformatf("rnd%0d", n), dq, eq);
            check($sformatf("rnd%0d data a=%h", n, addr), dq, exp_d);
            check($sformatf("rnd%0d err", n), 32'(eq), 32'(exp_e));
            if (w) model_write(addr, wd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
